// File: rtl/branch_hazard_ctrl.sv
// Branch hazard controller: stalls on a branch in ID until MEM resolves it, then flushes on taken.
// Optional statistics counters are built when BRANCH_HAZARD_STATS_EN is defined.
module branch_hazard_ctrl #(
    parameter int RESOLVE_LAT = 2,
    parameter int FLUSH_CYC   = 2,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_id,
    input  logic              res_valid,
    input  logic              res_taken,
    output logic              branchhazard,
    output logic              flush,
    output logic              busy,
    output logic              timeout_err
`ifdef BRANCH_HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] taken_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [3:0] RES_LAT_C   = 4'(RESOLVE_LAT);
    localparam logic [3:0] FLUSH_CYC_C = 4'(FLUSH_CYC);

    if (RESOLVE_LAT < 1 || RESOLVE_LAT > 15 || FLUSH_CYC < 1 || FLUSH_CYC > 7 || STAT_W < 1) begin : g_param_err
        $error("branch_hazard_ctrl: parameter out of legal range");
    end

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       branch_inc_s;
    logic       taken_inc_s;

    // State, shared wait/flush counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; branchhazard must react to branch_id/res_valid within the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        branchhazard = 1'b1;
        branch_inc_s = 1'b0;
        taken_inc_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (branch_id) begin
                    branchhazard = 1'b0;
                    cnt_d        = 4'd1;
                    state_d      = ST_WAIT;
                    branch_inc_s = 1'b1;
                end else begin
                    branchhazard = 1'b1;
                end
            end
            ST_WAIT: begin
                if (res_valid) begin
                    branchhazard = 1'b1;
                    if (res_taken) begin
                        state_d     = ST_FLUSH;
                        cnt_d       = FLUSH_CYC_C;
                        taken_inc_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    branchhazard = 1'b0;
                    // A resolution arriving in the final allowed cycle is taken above, so only a miss times out.
                    if (cnt_q >= RES_LAT_C) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign flush       = (state_q == ST_FLUSH);
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = err_q;

`ifdef BRANCH_HAZARD_STATS_EN
    logic [STAT_W-1:0] branch_cnt_q;
    logic [STAT_W-1:0] taken_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_q <= {STAT_W{1'b0}};
            taken_cnt_q  <= {STAT_W{1'b0}};
        end else begin
            if (branch_inc_s && (branch_cnt_q != {STAT_W{1'b1}})) begin
                branch_cnt_q <= branch_cnt_q + STAT_W'(1);
            end
            if (taken_inc_s && (taken_cnt_q != {STAT_W{1'b1}})) begin
                taken_cnt_q <= taken_cnt_q + STAT_W'(1);
            end
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;
`else
    logic unused_stats_s;
    assign unused_stats_s = branch_inc_s ^ taken_inc_s;
`endif

endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 SHALL have parameter RESOLVE_LAT, default 2, maximum cycles from branch detection in ID to resolution; legal range 1..15.
REQ-002 SHALL have parameter FLUSH_CYC, default 2, number of cycles flush is held after a taken branch; legal range 1..7.
REQ-003 SHALL have parameter STAT_W, default 16, width of the statistics counters.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 branch_id  input  1  branch instruction present in ID.
REQ-008 res_valid  input  1  branch resolution valid this cycle (MEM).
REQ-009 res_taken  input  1  resolved branch is taken; qualified by res_valid.
REQ-010 branchhazard  output  1  0 = stall PC/IF-ID, 1 = proceed.
REQ-011 flush  output  1  1 = flush IF/ID and ID/EX.
REQ-012 busy  output  1  1 when state is not IDLE.
REQ-013 timeout_err  output  1  sticky: resolution missing within RESOLVE_LAT cycles.
REQ-014 branch_cnt, taken_cnt  output  STAT_W each  statistics (present only per REQ-030).

Function
REQ-015 SHALL implement states IDLE, WAIT, FLUSH in a registered state machine.
REQ-016 IDLE: branch_id=1 -> branchhazard=0 combinationally in that cycle, wait counter loaded with 1, next state WAIT; branch_id=0 -> branchhazard=1, stay IDLE.
REQ-017 WAIT: branchhazard=0 except in a cycle with res_valid=1, where branchhazard=1.
REQ-018 WAIT, res_valid=1, res_taken=1 -> next state FLUSH, flush counter loaded with FLUSH_CYC.
REQ-019 WAIT, res_valid=1, res_taken=0 -> next state IDLE; flush never asserted.
REQ-020 WAIT, res_valid=0 -> wait counter increments; when counter equals RESOLVE_LAT, timeout_err sets, next state IDLE.
REQ-021 FLUSH: flush=1, branchhazard=1, counter decrements each cycle; at count 1 next state IDLE; flush=1 for exactly FLUSH_CYC cycles.
REQ-022 branch_id SHALL be ignored in WAIT and FLUSH (those instructions are stalled or flushed).
REQ-023 res_valid in IDLE or FLUSH SHALL be ignored; no state change, no error.
REQ-024 Resolution in the same cycle the counter reaches RESOLVE_LAT SHALL be accepted; timeout_err stays clear.
REQ-025 timeout_err SHALL stay set until reset.
REQ-026 busy SHALL be registered-state derived: 1 in WAIT and FLUSH.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, counters 0, flush=0, timeout_err=0, busy=0, branchhazard=1 (when branch_id=0), statistics 0.
REQ-028 Reset asserted mid-WAIT or mid-FLUSH SHALL abort the sequence with no further flush cycles.
REQ-029 First rising clk edge after reset deassertion SHALL be a normal IDLE cycle.

Configuration
REQ-030 Macro BRANCH_HAZARD_STATS_EN defined: branch_cnt increments on each IDLE->WAIT transition, taken_cnt on each WAIT->FLUSH transition; both saturate at all-ones.
REQ-031 Macro BRANCH_HAZARD_STATS_EN undefined: branch_cnt and taken_cnt ports and counters are absent; all other behaviour identical.

Verification
REQ-032 Not-taken: branch_id=1 at cycle 0, res_valid=1 res_taken=0 at cycle 2 -> branchhazard=0 cycles 0-1, 1 cycle 2, flush never 1, busy=0 from cycle 3.
REQ-033 Taken, FLUSH_CYC=2: res_valid=1 res_taken=1 at cycle 2 -> flush=1 cycles 3-4, 0 at cycle 5, branchhazard=1 from cycle 2.
REQ-034 Timeout, RESOLVE_LAT=2: branch_id at cycle 0, no res_valid -> timeout_err=1 from cycle 3, state IDLE cycle 3, stays set until reset.
REQ-035 Reset mid-FLUSH: reset=0 during first flush cycle -> flush=0 immediately, busy=0, no further flush.
REQ-036 Back-to-back: branch_id held 1 for 6 cycles, taken at cycle 2 -> second branch detected only after FLUSH ends (cycle 5); branch_cnt=2, taken_cnt=1 with BRANCH_HAZARD_STATS_EN.
REQ-037 Saturation, STAT_W=2, BRANCH_HAZARD_STATS_EN: 5 not-taken branches -> branch_cnt=3.
